// File: rtl/calc_issue_ctrl.sv
// Initiator side of the calculate-unit interface: registers a request onto the
// calculate unit, captures its fast or slow answer, and returns a tagged result.
// Optional performance counters are enabled with `define CALC_PERF_CNT_EN.
module calc_issue_ctrl #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_num1,
  input  logic [31:0]      req_num2,
  input  logic [7:0]       req_mode,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [3:0]       resp_error,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy,
  output logic [31:0]      ccu_number1,
  output logic [31:0]      ccu_number2,
  output logic [7:0]       ccu_mode,
  input  logic [31:0]      ccu_fast_answer,
  input  logic [31:0]      ccu_slow_answer,
  input  logic [3:0]       ccu_error
`ifdef CALC_PERF_CNT_EN
  ,
  output logic [31:0]      perf_fast_cnt,
  output logic [31:0]      perf_slow_cnt,
  output logic [31:0]      perf_err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    SLOW,
    RESP
  } state_t;

  localparam logic [3:0] ERR_NO_INSTRUCTION = 4'h1;

  state_t           state_q, state_d;
  logic [TAG_W-1:0] tag_q;
  logic [3:0]       err_q;
  logic             accept;
  logic             is_fast;
  logic             is_slow;

  // The mode register is held until the next accept, so it still describes
  // the in-flight operation while its response is being handed off.
  assign is_fast = (ccu_mode[7:6] == 2'b00);
  assign is_slow = (ccu_mode[7:4] == 4'h4);

  assign req_ready  = (state_q == IDLE) || ((state_q == RESP) && resp_ready);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_tag   = (state_q == RESP) ? tag_q : '0;
  assign busy       = (state_q != IDLE);

  // NOTE: the default assignment first guarantees state_d is written on every
  // path, so no latch is inferred when a case arm leaves it untouched.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: state_d = is_slow ? SLOW : RESP;
      SLOW: state_d = RESP;
      RESP: begin
        if (resp_ready) state_d = accept ? EXEC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every datapath register is reset as well, because an aborted
  // transaction must leave no stale operands or result on the outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ccu_number1 <= '0;
      ccu_number2 <= '0;
      ccu_mode    <= 8'h00;
      tag_q       <= '0;
      err_q       <= '0;
      resp_data   <= '0;
      resp_error  <= '0;
    end else begin
      if (accept) begin
        ccu_number1 <= req_num1;
        ccu_number2 <= req_num2;
        ccu_mode    <= req_mode;
        tag_q       <= req_tag;
      end
      unique case (state_q)
        EXEC: begin
          if (is_fast) begin
            resp_data  <= ccu_fast_answer;
            resp_error <= ccu_error;
          end else if (is_slow) begin
            err_q <= ccu_error;
          end else begin
            resp_data  <= '0;
            resp_error <= ERR_NO_INSTRUCTION;
          end
        end
        SLOW: begin
          resp_data  <= ccu_slow_answer;
          resp_error <= err_q;
        end
        default: ;
      endcase
    end
  end

`ifdef CALC_PERF_CNT_EN
  logic resp_fire;
  assign resp_fire = resp_valid && resp_ready;

  // Counters wrap naturally at 32 bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_fast_cnt <= '0;
      perf_slow_cnt <= '0;
      perf_err_cnt  <= '0;
    end else if (resp_fire) begin
      if (is_fast)            perf_fast_cnt <= perf_fast_cnt + 32'd1;
      if (is_slow)            perf_slow_cnt <= perf_slow_cnt + 32'd1;
      if (resp_error != 4'h0) perf_err_cnt  <= perf_err_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_calc_issue_ctrl.sv
// Self-checking bench for calc_issue_ctrl: behavioural calculate unit, a
// scoreboard queue of expected responses, and directed stimulus steps.
module tb_calc_issue_ctrl;

  localparam int TAG_W = 5;

  typedef struct {
    logic [31:0]      data;
    logic [3:0]       err;
    logic [TAG_W-1:0] tag;
    int               drv_cyc;
    int               lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rstn;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_num1;
  logic [31:0]      req_num2;
  logic [7:0]       req_mode;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [3:0]       resp_error;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;
  logic [31:0]      ccu_number1;
  logic [31:0]      ccu_number2;
  logic [7:0]       ccu_mode;
  logic [31:0]      ccu_fast_answer;
  logic [31:0]      ccu_slow_answer;
  logic [3:0]       ccu_error;
`ifdef CALC_PERF_CNT_EN
  logic [31:0]      perf_fast_cnt;
  logic [31:0]      perf_slow_cnt;
  logic [31:0]      perf_err_cnt;
`endif

  int   tests  = 0;
  int   failed = 0;
  int   cyc    = 0;
  bit   seen   = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

  calc_issue_ctrl #(.TAG_W(TAG_W)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_num1        (req_num1),
    .req_num2        (req_num2),
    .req_mode        (req_mode),
    .req_tag         (req_tag),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_data       (resp_data),
    .resp_error      (resp_error),
    .resp_tag        (resp_tag),
    .busy            (busy),
    .ccu_number1     (ccu_number1),
    .ccu_number2     (ccu_number2),
    .ccu_mode        (ccu_mode),
    .ccu_fast_answer (ccu_fast_answer),
    .ccu_slow_answer (ccu_slow_answer),
    .ccu_error       (ccu_error)
`ifdef CALC_PERF_CNT_EN
    ,
    .perf_fast_cnt   (perf_fast_cnt),
    .perf_slow_cnt   (perf_slow_cnt),
    .perf_err_cnt    (perf_err_cnt)
`endif
  );

  // Behavioural calculate unit: {error, answer} for a mode and operands.
  function automatic logic [35:0] ccu_model(input logic [7:0] m,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    case (m)
      8'h00:   return {4'h0, a - b};
      8'h01:   return {4'h0, a + b};
      8'h3F:   return {4'hB, 32'hDEAD_BEEF};
      8'h40:   return {4'h0, a * b};
      8'h45:   if (b == 32'd0) return {4'h2, 32'hFFFF_FFFF};
               else            return {4'h0, a / b};
      8'h55,
      8'hFF:   return {4'hF, 32'h1234_5678};
      default: return {4'h1, 32'h0};
    endcase
  endfunction

  logic [35:0] ccu_res;
  assign ccu_res         = ccu_model(ccu_mode, ccu_number1, ccu_number2);
  assign ccu_error       = ccu_res[35:32];
  // A slow-class fast answer is deliberately bogus so a wrong capture shows.
  assign ccu_fast_answer = (ccu_mode[7:4] == 4'h4) ? 32'hBAD0_BAD0 : ccu_res[31:0];
  always @(posedge clk) ccu_slow_answer <= ccu_res[31:0];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Response side, evaluated with inputs settled just before each active edge.
  task automatic monitor();
    exp_t e;
    if (resp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", {31'd0, resp_valid}, 32'd0);
      end else begin
        e = sb[0];
        if (!seen) begin
          check("latency", cyc - e.drv_cyc, e.lat);
          seen = 1'b1;
        end
        if (resp_ready) begin
          check("resp_data", resp_data, e.data);
          check("resp_error", {28'd0, resp_error}, {28'd0, e.err});
          check("resp_tag", {27'd0, resp_tag}, {27'd0, e.tag});
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  endtask

  task automatic cycle();
    monitor();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [7:0] m, input logic [TAG_W-1:0] t);
    exp_t        e;
    logic [35:0] r;
    bit          done = 1'b0;
    req_num1  = a;
    req_num2  = b;
    req_mode  = m;
    req_tag   = t;
    req_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (req_ready) begin
        r         = ccu_model(m, a, b);
        e.tag     = t;
        e.drv_cyc = cyc;
        if (m[7:6] == 2'b00) begin
          e.data = r[31:0]; e.err = r[35:32]; e.lat = 2;
        end else if (m[7:4] == 4'h4) begin
          e.data = r[31:0]; e.err = r[35:32]; e.lat = 3;
        end else begin
          e.data = 32'd0;   e.err = 4'h1;     e.lat = 2;
        end
        sb.push_back(e);
        done = 1'b1;
      end
      cycle();
    end
    req_valid = 1'b0;
    check("accept_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) cycle();
    check("drain", sb.size(), 32'd0);
  endtask

  initial begin
    rstn       = 1'b0;
    req_valid  = 1'b0;
    req_num1   = '0;
    req_num2   = '0;
    req_mode   = '0;
    req_tag    = '0;
    resp_ready = 1'b1;
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_error", {28'd0, resp_error}, 32'd0);
    check("rst_resp_tag", {27'd0, resp_tag}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ccu_num1", ccu_number1, 32'd0);
    check("rst_ccu_mode", {24'd0, ccu_mode}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    cycle();

    // Fast ADD
    issue(32'd5, 32'd7, 8'h01, 5'd3);
    drain();

    // Slow MUL with operand stability through EXEC and SLOW
    issue(32'd6, 32'd7, 8'h40, 5'd9);
    for (int i = 0; i < 2; i++) begin
      check("ccu_num1_stable", ccu_number1, 32'd6);
      check("ccu_num2_stable", ccu_number2, 32'd7);
      check("ccu_mode_stable", {24'd0, ccu_mode}, 32'h40);
      check("busy_mid", {31'd0, busy}, 32'd1);
      cycle();
    end
    drain();
    check("ccu_mode_idle", {24'd0, ccu_mode}, 32'h40);

    // Divide by zero, unsupported classes, full 4-bit error forwarding
    issue(32'd100, 32'd0, 8'h45, 5'd1);
    drain();
    issue(32'd8, 32'd2, 8'h55, 5'd2);
    drain();
    issue(32'd8, 32'd2, 8'hFF, 5'd31);
    drain();
    issue(32'd0, 32'd0, 8'h3F, 5'd17);
    drain();

    // Response backpressure
    resp_ready = 1'b0;
    issue(32'd10, 32'd3, 8'h00, 5'd4);
    cycle();
    for (int i = 0; i < 4; i++) begin
      check("stall_valid", {31'd0, resp_valid}, 32'd1);
      check("stall_data", resp_data, 32'd7);
      check("stall_tag", {27'd0, resp_tag}, 32'd4);
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
      cycle();
    end
    resp_ready = 1'b1;
    cycle();
    check("stall_release", {31'd0, resp_valid}, 32'd0);
    check("stall_busy", {31'd0, busy}, 32'd0);
    check("stall_sb_empty", sb.size(), 32'd0);

    // Back-to-back issue
    issue(32'd1, 32'd1, 8'h01, 5'd10);
    issue(32'd3, 32'd3, 8'h40, 5'd11);
    issue(32'd2, 32'd2, 8'h01, 5'd12);
    drain();

    // Reset during SLOW
    issue(32'd5, 32'd5, 8'h40, 5'd20);
    cycle();
    check("pre_rst_slow_busy", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    #1;
    check("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_req_ready", {31'd0, req_ready}, 32'd1);
    check("arst_ccu_num1", ccu_number1, 32'd0);
    check("arst_ccu_num2", ccu_number2, 32'd0);
    check("arst_ccu_mode", {24'd0, ccu_mode}, 32'd0);
    check("arst_resp_data", resp_data, 32'd0);
    sb.delete();
    seen = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    issue(32'd1, 32'd2, 8'h01, 5'd7);
    drain();
    cycle();
`ifdef CALC_PERF_CNT_EN
    check("perf_fast", perf_fast_cnt, 32'd1);
    check("perf_slow", perf_slow_cnt, 32'd0);
    check("perf_err", perf_err_cnt, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
